// File: rtl/muldiv_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 multiply / restoring divide with HI/LO accumulator; 32 RUN cycles + 1 FIX cycle,
// result written at the FIX->IDLE edge. Busy is a registered state decode; Start is ignored while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_t             r_state, w_state_nxt;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_work;
  logic [WIDTH-1:0]   r_a, r_b, r_a_raw, r_hi, r_lo;
  logic [2:0]         r_op;
  logic               r_neg_p, r_neg_r, r_done;

  logic               w_signed, w_start, w_is_div, w_busy, w_qbit;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_prod, w_res;
  logic [WIDTH:0]     w_rem_sh, w_diff;

  assign w_signed = ~Op[0];
  assign w_start  = (r_state == IDLE) & Start & ~Flush;
  assign w_is_div = (r_op == OP_DIV) | (r_op == OP_DIVU);
  assign w_abs_a  = (w_signed & A[WIDTH-1]) ? -A : A;
  assign w_abs_b  = (w_signed & B[WIDTH-1]) ? -B : B;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = RUN;
      RUN:     if (Flush) w_state_nxt = IDLE;
               else if (r_cnt == 5'(ITER - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  // Multiply consumes the multiplier MSB-first (Horner); divide consumes the dividend MSB-first.
  assign w_mul_step = {r_work[2*WIDTH-2:0], 1'b0} + (r_b[WIDTH-1] ? {{WIDTH{1'b0}}, r_a} : '0);
  assign w_rem_sh   = {r_work[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_div_step = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_work[WIDTH-2:0], w_qbit};

  assign w_quo  = r_work[WIDTH-1:0];
  assign w_rem  = r_work[2*WIDTH-1:WIDTH];
  assign w_prod = r_neg_p ? (-r_work) : r_work;

  always_comb begin
    w_res = w_prod;
    case (r_op)
      OP_MADD, OP_MADDU: w_res = {r_hi, r_lo} + w_prod;
      OP_MSUB, OP_MSUBU: w_res = {r_hi, r_lo} - w_prod;
      OP_DIV, OP_DIVU: begin
        if (r_b == '0) w_res = {r_a_raw, {WIDTH{1'b1}}};
        else           w_res = {(r_neg_r ? -w_rem : w_rem), (r_neg_p ? -w_quo : w_quo)};
      end
      default:           w_res = w_prod;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_work  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_a_raw <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= OP_MULT;
      r_neg_p <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == FIX) & ~Flush;
      case (r_state)
        IDLE: begin
          if (WriteHi) r_hi <= WriteData;
          if (WriteLo) r_lo <= WriteData;
          if (w_start) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_a_raw <= A;
            r_op    <= Op;
            r_neg_p <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r <= w_signed & A[WIDTH-1];
            r_work  <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_is_div) begin
            r_work <= w_div_step;
            r_a    <= r_a << 1;
          end else begin
            r_work <= w_mul_step;
            r_b    <= r_b << 1;
          end
        end
        FIX: begin
          if (!Flush) {r_hi, r_lo} <= w_res;
        end
        default: ;
      endcase
    end
  end

  assign Busy = w_busy;
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, timing, flush and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Flush = 1'b0;
  logic        WriteHi = 1'b0;
  logic        WriteLo = 1'b0;
  logic [31:0] WriteData = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts an op at the next edge and returns in the Done cycle, 33 edges later.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int busy_n = 0;
    int done_n = 0;
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    if (Busy) busy_n++;
    if (Done) done_n++;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (Busy) busy_n++;
      if (Done) done_n++;
    end
    check({tag, " busy cycles"}, 64'(busy_n), 64'd33);
    check({tag, " early done"}, 64'(done_n), 64'd0);
    tick();
    check({tag, " done"}, 64'(Done), 64'd1);
    check({tag, " busy off"}, 64'(Busy), 64'd0);
    check({tag, " hi"}, 64'(Hi), 64'(eh));
    check({tag, " lo"}, 64'(Lo), 64'(el));
  endtask

  initial begin
    int busy_n;
    int done_n;

    tick();
    tick();
    check("reset hi", 64'(Hi), 64'd0);
    check("reset lo", 64'(Lo), 64'd0);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    Reset = 1'b0;
    tick();

    run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    tick();
    check("done pulse width", 64'(Done), 64'd0);

    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    WriteHi = 1'b1; WriteData = 32'h0;
    tick();
    WriteHi = 1'b0;
    check("mthi", 64'(Hi), 64'd0);
    // MTLO in the same cycle as Start: accumulation sees the written value.
    WriteLo = 1'b1; WriteData = 32'hFFFFFFFF;
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'h00000001, 32'h00000000);

    // Started in the Done cycle of the previous op.
    run_op("div neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu by0", OP_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    run_op("div by0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    WriteLo = 1'b1; WriteData = 32'h0;
    run_op("msub", OP_MSUB, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("madd", OP_MADD, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFF9);
    run_op("divu", OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'h00000005, 32'h19999999);
    tick();

    // Flush: Start ignored while busy, MTHI ignored while busy, no Done.
    Start = 1'b1; Op = OP_MULT; A = 32'd5; B = 32'd6;
    tick();
    Start = 1'b0;
    check("flush op busy", 64'(Busy), 64'd1);
    repeat (4) tick();
    Start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd3;
    tick();
    Start = 1'b0;
    WriteHi = 1'b1; WriteData = 32'hDEAD;
    tick();
    WriteHi = 1'b0;
    repeat (3) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush busy", 64'(Busy), 64'd0);
    check("flush hi", 64'(Hi), 64'h5);
    check("flush lo", 64'(Lo), 64'h19999999);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busy_n++;
      if (Done) done_n++;
      tick();
    end
    check("flush no done", 64'(done_n), 64'd0);
    check("flush stays idle", 64'(busy_n), 64'd0);
    check("flush hi later", 64'(Hi), 64'h5);

    Start = 1'b1; Flush = 1'b1; Op = OP_MULT;
    tick();
    Start = 1'b0; Flush = 1'b0;
    check("idle flush drops start", 64'(Busy), 64'd0);

    // Asynchronous reset mid-divide.
    WriteHi = 1'b1; WriteData = 32'h1234;
    tick();
    WriteHi = 1'b0; WriteLo = 1'b1; WriteData = 32'h5678;
    tick();
    WriteLo = 1'b0;
    check("preload hi", 64'(Hi), 64'h1234);
    check("preload lo", 64'(Lo), 64'h5678);
    Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0;
    repeat (11) tick();
    Reset = 1'b1;
    #1;
    check("areset hi", 64'(Hi), 64'd0);
    check("areset lo", 64'(Lo), 64'd0);
    check("areset busy", 64'(Busy), 64'd0);
    check("areset done", 64'(Done), 64'd0);
    tick();
    Reset = 1'b0;
    run_op("mult after reset", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12);
    tick();
    check("final done low", 64'(Done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
